// File: rtl/key_event_decoder_if.sv
// Keycode/freeze inputs and game-command outputs of the key event decoder.
// The decoder takes the slave view and the host/top level takes the master view.
interface key_event_decoder_if #(
    parameter int NUM_FROGS = 3,
    parameter int KEY_SLOTS = 2
);
    logic [8*KEY_SLOTS-1:0] keycode;
    logic                   freeze;
    logic [3:0]             dir_event;
    logic [3:0]             dir_held;
    logic [3:0]             last_dir;
    logic [NUM_FROGS-1:0]   active_frog;

    modport master (
        output keycode, freeze,
        input  dir_event, dir_held, last_dir, active_frog
    );

    modport slave (
        input  keycode, freeze,
        output dir_event, dir_held, last_dir, active_frog
    );
endinterface

// File: rtl/key_event_decoder.sv
// Turns multi-slot USB keycodes into frog direction events with auto-repeat and frog selection.
// Events are held until a frame tick after they are set, so the frame_clk domain samples each one once.
module key_event_decoder #(
    parameter int         NUM_FROGS     = 3,
    parameter logic [7:0] FROG_KEY_BASE = 8'h59,
    parameter int         KEY_SLOTS     = 2,
    parameter int         REPEAT_DELAY  = 30,
    parameter int         REPEAT_RATE   = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    key_event_decoder_if.slave kif
);
    localparam logic [7:0]           DELAY_LD = 8'(REPEAT_DELAY);
    localparam logic [7:0]           RATE_LD  = 8'(REPEAT_RATE);
    localparam logic [NUM_FROGS-1:0] FROG_ONE = NUM_FROGS'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [7:0] slot_code_s [KEY_SLOTS];
    logic [3:0] slot_dir_s  [KEY_SLOTS];
    logic [7:0] slot_idx_s  [KEY_SLOTS];
    logic       slot_frog_s [KEY_SLOTS];

    logic [3:0] cur_dir_s;
    logic       frog_hit_s;
    logic [7:0] frog_idx_s;
    logic       tick_s;
    logic       fire_s;
    logic [3:0] fire_dir_s;
    logic [7:0] cnt_dec_s;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           trk_q, trk_d;
    logic [2:0]           fs_q, fs_d;
    logic [3:0]           dir_event_q, dir_event_d;
    logic [3:0]           dir_held_q, dir_held_d;
    logic [3:0]           last_dir_q, last_dir_d;
    logic [NUM_FROGS-1:0] active_frog_q, active_frog_d;

    for (genvar s = 0; s < KEY_SLOTS; s++) begin : g_slot
        assign slot_code_s[s] = kif.keycode[8*s +: 8];
        assign slot_dir_s[s]  = (slot_code_s[s] == 8'h52) ? 4'b0001 :
                                (slot_code_s[s] == 8'h51) ? 4'b0010 :
                                (slot_code_s[s] == 8'h50) ? 4'b0100 :
                                (slot_code_s[s] == 8'h4f) ? 4'b1000 : 4'b0000;
        assign slot_idx_s[s]  = slot_code_s[s] - FROG_KEY_BASE;
        assign slot_frog_s[s] = (slot_code_s[s] >= FROG_KEY_BASE) &&
                                (slot_idx_s[s] < 8'(NUM_FROGS));
    end

    // Priority scan: walking from the top slot down lets the lowest slot overwrite.
    always_comb begin
        cur_dir_s  = 4'b0000;
        frog_hit_s = 1'b0;
        frog_idx_s = 8'd0;
        for (int s = KEY_SLOTS - 1; s >= 0; s--) begin
            cur_dir_s  = (slot_dir_s[s] != 4'b0000) ? slot_dir_s[s] : cur_dir_s;
            frog_idx_s = slot_frog_s[s] ? slot_idx_s[s] : frog_idx_s;
            frog_hit_s = frog_hit_s | slot_frog_s[s];
        end
    end

    // Next-state logic for the repeat FSM, the event hold window and the sticky outputs.
    always_comb begin
        fs_d       = {fs_q[1:0], frame_clk};
        tick_s     = fs_q[1] & ~fs_q[2];
        state_d    = state_q;
        cnt_d      = cnt_q;
        trk_d      = trk_q;
        fire_s     = 1'b0;
        fire_dir_s = trk_q;
        cnt_dec_s  = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : 8'd0;

        case (state_q)
            S_IDLE: begin
                if ((cur_dir_s != 4'b0000) && !kif.freeze) begin
                    fire_s     = 1'b1;
                    fire_dir_s = cur_dir_s;
                    trk_d      = cur_dir_s;
                    cnt_d      = DELAY_LD;
                    state_d    = S_DELAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (kif.freeze || (cur_dir_s == 4'b0000)) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cur_dir_s != trk_q) begin
                    fire_s     = 1'b1;
                    fire_dir_s = cur_dir_s;
                    trk_d      = cur_dir_s;
                    cnt_d      = DELAY_LD;
                    state_d    = S_DELAY;
                end else if (tick_s) begin
                    // A zero rate parks the counter at 0 in DELAY with no further events.
                    if ((cnt_dec_s == 8'd0) && (RATE_LD != 8'd0)) begin
                        fire_s  = 1'b1;
                        cnt_d   = RATE_LD;
                        state_d = S_REPEAT;
                    end else begin
                        cnt_d = cnt_dec_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        dir_event_d   = fire_s ? fire_dir_s : (tick_s ? 4'b0000 : dir_event_q);
        last_dir_d    = fire_s ? fire_dir_s : last_dir_q;
        dir_held_d    = kif.freeze ? 4'b0000 : cur_dir_s;
        active_frog_d = frog_hit_s ? (FROG_ONE << frog_idx_s) : active_frog_q;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            trk_q         <= 4'b0000;
            fs_q          <= 3'b000;
            dir_event_q   <= 4'b0000;
            dir_held_q    <= 4'b0000;
            last_dir_q    <= 4'b0000;
            active_frog_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trk_q         <= trk_d;
            fs_q          <= fs_d;
            dir_event_q   <= dir_event_d;
            dir_held_q    <= dir_held_d;
            last_dir_q    <= last_dir_d;
            active_frog_q <= active_frog_d;
        end
    end

    assign kif.dir_event   = dir_event_q;
    assign kif.dir_held    = dir_held_q;
    assign kif.last_dir    = last_dir_q;
    assign kif.active_frog = active_frog_q;
endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: a tick-counting reference model is compared every cycle,
// and literal expectations pin event counts seen at frame_clk edges and frog selection.
module tb_key_event_decoder;
    localparam int         NF    = 3;
    localparam int         SLOTS = 2;
    localparam logic [7:0] BASE  = 8'h59;
    localparam int         DLY   = 30;
    localparam int         RATE  = 8;

    logic Clk;
    logic Reset;
    logic frame_clk;

    key_event_decoder_if #(.NUM_FROGS(NF), .KEY_SLOTS(SLOTS)) kif ();

    key_event_decoder #(
        .NUM_FROGS(NF), .FROG_KEY_BASE(BASE), .KEY_SLOTS(SLOTS),
        .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .kif(kif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int seen_cnt = 0;
    logic [3:0] seen_or = 4'b0000;

    // reference model state: how long the tracked key has been held, counted in ticks
    logic [3:0]    e_event = 4'b0000, e_held = 4'b0000, e_last = 4'b0000;
    logic [NF-1:0] e_frog = '0;
    bit            m_act = 1'b0;
    logic [3:0]    m_dir = 4'b0000;
    int            m_ticks = 0;
    bit            h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial frame_clk = 1'b0;
    always begin
        repeat (4) @(negedge Clk);
        frame_clk = ~frame_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dir_of(input logic [7:0] c);
        case (c)
            8'h52:   return 4'b0001;
            8'h51:   return 4'b0010;
            8'h50:   return 4'b0100;
            8'h4f:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step(input logic [8*SLOTS-1:0] kc, input logic frz, input bit tk);
        logic [3:0] cur;
        logic [7:0] c;
        bit         ff;
        int         fidx;
        bit         fire;
        logic [3:0] fv;
        cur = 4'b0000; ff = 1'b0; fidx = 0; fire = 1'b0; fv = 4'b0000;
        for (int s = 0; s < SLOTS; s++) begin
            c = kc[8*s +: 8];
            if (cur == 4'b0000) cur = dir_of(c);
            if (!ff && (int'(c) >= int'(BASE)) && (int'(c) - int'(BASE) < NF)) begin
                ff = 1'b1;
                fidx = int'(c) - int'(BASE);
            end
        end
        if (!m_act) begin
            if (cur != 4'b0000 && !frz) begin
                fire = 1'b1; fv = cur; m_act = 1'b1; m_dir = cur; m_ticks = 0;
            end
        end else if (frz || cur == 4'b0000) begin
            m_act = 1'b0;
        end else if (cur != m_dir) begin
            fire = 1'b1; fv = cur; m_dir = cur; m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == DLY || (RATE > 0 && m_ticks > DLY && (m_ticks - DLY) % RATE == 0)) begin
                fire = 1'b1; fv = m_dir;
            end
        end
        e_held = frz ? 4'b0000 : cur;
        if (fire) begin
            e_event = fv;
            e_last  = fv;
        end else if (tk) begin
            e_event = 4'b0000;
        end
        if (ff) e_frog = NF'(1) << fidx;
    endtask

    // the frame_clk rise becomes a tick two Clk samples later
    always @(posedge Clk) begin
        if (Reset) begin
            e_event = 4'b0000; e_held = 4'b0000; e_last = 4'b0000; e_frog = '0;
            m_act = 1'b0; m_dir = 4'b0000; m_ticks = 0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            model_step(kif.keycode, kif.freeze, h2 && !h3);
            h3 = h2; h2 = h1; h1 = frame_clk;
        end
        #1;
        chk("model_dir_event", kif.dir_event, e_event);
        chk("model_dir_held", kif.dir_held, e_held);
        chk("model_last_dir", kif.last_dir, e_last);
        chk("model_active_frog", kif.active_frog, e_frog);
    end

    always @(posedge frame_clk) begin
        if (!Reset && kif.dir_event != 4'b0000) begin
            seen_cnt++;
            seen_or |= kif.dir_event;
        end
    end

    task automatic wait_frames(input int n);
        repeat (n) @(posedge frame_clk);
        repeat (3) @(negedge Clk);
    endtask

    task automatic clear_seen();
        seen_cnt = 0;
        seen_or  = 4'b0000;
    endtask

    initial begin
        Reset = 1'b1;
        kif.keycode = '0;
        kif.freeze = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_dir_event", kif.dir_event, 4'b0000);
        chk("reset_last_dir", kif.last_dir, 4'b0000);
        chk("reset_active_frog", kif.active_frog, 3'b000);
        Reset = 1'b0;

        // single up press held for 5 ticks
        @(negedge frame_clk); clear_seen(); kif.keycode = 16'h0052;
        wait_frames(5);
        chk("up_seen_cnt", seen_cnt, 1);
        chk("up_seen_val", seen_or, 4'b0001);
        chk("up_event_cleared", kif.dir_event, 4'b0000);
        chk("up_held", kif.dir_held, 4'b0001);
        chk("up_last", kif.last_dir, 4'b0001);
        @(negedge frame_clk); kif.keycode = '0;
        wait_frames(2);

        // left held 50 ticks: events at ticks 0, 30, 38, 46
        @(negedge frame_clk); clear_seen(); kif.keycode = 16'h0050;
        wait_frames(50);
        chk("left_seen_cnt", seen_cnt, 4);
        chk("left_seen_val", seen_or, 4'b0100);
        chk("left_last", kif.last_dir, 4'b0100);
        @(negedge frame_clk); kif.keycode = '0;
        wait_frames(2);

        // slot 0 wins, then a new direction restarts the delay
        @(negedge frame_clk); kif.keycode = 16'h4F52;
        repeat (2) @(negedge Clk);
        chk("slot0_up_event", kif.dir_event, 4'b0001);
        @(negedge frame_clk); clear_seen(); kif.keycode = 16'h004F;
        repeat (2) @(negedge Clk);
        chk("right_press_event", kif.dir_event, 4'b1000);
        wait_frames(29);
        chk("right_no_early_repeat", seen_cnt, 1);
        wait_frames(2);
        chk("right_repeat_at_30", seen_cnt, 2);
        @(negedge frame_clk); kif.keycode = '0;
        wait_frames(2);

        // frog selection
        @(negedge Clk); kif.keycode = 16'h005A;
        repeat (2) @(negedge Clk);
        chk("frog1_select", kif.active_frog, 3'b010);
        kif.keycode = 16'h0000;
        repeat (2) @(negedge Clk);
        chk("frog1_sticky", kif.active_frog, 3'b010);
        kif.keycode = 16'h005C;
        repeat (2) @(negedge Clk);
        chk("frog3_ignored", kif.active_frog, 3'b010);
        kif.keycode = 16'h5B59;
        repeat (2) @(negedge Clk);
        chk("frog_low_slot_wins", kif.active_frog, 3'b001);
        kif.keycode = 16'h0000;

        // freeze blocks direction events
        @(negedge frame_clk); clear_seen(); kif.freeze = 1'b1; kif.keycode = 16'h0051;
        wait_frames(10);
        chk("freeze_seen_cnt", seen_cnt, 0);
        chk("freeze_held", kif.dir_held, 4'b0000);
        @(negedge frame_clk); kif.freeze = 1'b0;
        @(negedge Clk);
        chk("unfreeze_event", kif.dir_event, 4'b0010);
        @(negedge frame_clk); kif.keycode = '0;
        wait_frames(2);

        // asynchronous reset during an event window
        @(negedge frame_clk); kif.keycode = 16'h004F;
        for (int i = 0; i < 20 && kif.dir_event != 4'b1000; i++) @(negedge Clk);
        chk("pre_reset_event", kif.dir_event, 4'b1000);
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_dir_event", kif.dir_event, 4'b0000);
        chk("async_rst_dir_held", kif.dir_held, 4'b0000);
        chk("async_rst_last_dir", kif.last_dir, 4'b0000);
        chk("async_rst_active_frog", kif.active_frog, 3'b000);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_reset_press", kif.dir_event, 4'b1000);
        chk("post_reset_last", kif.last_dir, 4'b1000);
        @(negedge frame_clk); kif.keycode = '0;
        wait_frames(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
